// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_pkg
// Description : Shared types and constants for mem_latency_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    // Width of the latency down-counter; covers latencies 1..15.
    localparam int LAT_CNT_W = 4;

    // Data returned for a read of an address outside the array.
    localparam logic [31:0] OOR_RDATA = 32'h0;

    // Counter preload for a given latency: the completing edge is the one
    // at which the counter has reached zero.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
        return LAT_CNT_W'(lat - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_array
// Description : Single-port synchronous word RAM, write-first, not reset.
//               Read data register only updates when a read is requested so
//               the last read value is held between accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_word_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_index,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Synchronous write and held registered read (write data forwarded).
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= i_we ? i_wdata : r_mem[i_index];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_latency_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_latency_responder
// Description : Main-memory responder for the cache memory port. Accepts one
//               word access at a time, holds busy_mem for RD_LAT / WR_LAT
//               cycles, flags out-of-range addresses (sticky addr_err).
//               Optional build macro MEM_STATS_EN enables the completed
//               read/write counters; otherwise they read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_latency_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_mem,
    input  logic              rd_mem,
    input  logic [31:0]       addr_mem,
    input  logic [DATA_W-1:0] data_wr_mem,
    output logic [DATA_W-1:0] data_rd_mem,
    output logic              busy_mem,
    output logic              addr_err,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    state_t                r_state;
    state_t                w_next_state;
    logic [LAT_CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]     r_idx;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_oor;
    logic                  r_busy;
    logic                  r_addr_err;
    logic                  r_rd_valid;
    logic                  r_rd_oor;
    logic                  w_accept;
    logic                  w_rd_done;
    logic                  w_wr_done;
    logic                  w_we;
    logic                  w_re;
    logic                  w_oor;
    logic [DATA_W-1:0]     w_ram_rdata;
    logic                  w_unused_lsbs;

    // Byte-lane bits are irrelevant for word accesses.
    assign w_unused_lsbs = ^addr_mem[1:0];
    assign w_oor         = |addr_mem[31:ADDR_W+2];

    // State register; async reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle strobes; write wins over a simultaneous read.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_rd_done    = 1'b0;
        w_wr_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (wr_mem || rd_mem) begin
                    w_accept     = 1'b1;
                    w_next_state = wr_mem ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_rd_done    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            WR_WAIT: begin
                if (r_cnt == '0) begin
                    w_wr_done    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Out-of-range accesses are timed normally but never touch the array.
    assign w_we = w_wr_done && !r_oor;
    assign w_re = w_rd_done && !r_oor;

    // Latched access parameters; only meaningful while waiting.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= addr_mem[ADDR_W+1:2];
            r_wdata <= data_wr_mem;
            r_oor   <= w_oor;
        end
    end

    // Latency counter, busy flag, sticky error and read-result tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_addr_err <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_oor   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt  <= wr_mem ? lat_load(WR_LAT) : lat_load(RD_LAT);
                r_busy <= 1'b1;
                if (w_oor) begin
                    r_addr_err <= 1'b1;
                end
            end else if (w_rd_done || w_wr_done) begin
                r_busy <= 1'b0;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_rd_done) begin
                r_rd_valid <= 1'b1;
                r_rd_oor   <= r_oor;
            end
        end
    end

    mem_word_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_index (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Read data is the held RAM register, or zero before any in-range read.
    assign data_rd_mem = (r_rd_valid && !r_rd_oor) ? w_ram_rdata : DATA_W'(OOR_RDATA);
    assign busy_mem    = r_busy;
    assign addr_err    = r_addr_err;

`ifdef MEM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    // Completed-access counters, wrapping naturally at 2**32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_rd_done) begin
                r_rd_count <= r_rd_count + 32'd1;
            end
            if (w_wr_done) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_latency_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_latency_responder
// Description : Directed self-checking bench for mem_latency_responder
//               (default parameters). Honours MEM_STATS_EN for counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_latency_responder;

    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;
`ifdef MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        wr_mem;
    logic        rd_mem;
    logic [31:0] addr_mem;
    logic [31:0] data_wr_mem;
    logic [31:0] data_rd_mem;
    logic        busy_mem;
    logic        addr_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int checks = 0;
    int errors = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    mem_latency_responder #(
        .ADDR_W (10),
        .DATA_W (32),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_mem      (wr_mem),
        .rd_mem      (rd_mem),
        .addr_mem    (addr_mem),
        .data_wr_mem (data_wr_mem),
        .data_rd_mem (data_rd_mem),
        .busy_mem    (busy_mem),
        .addr_err    (addr_err),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access from a negedge: checks acceptance and busy length, ends on a negedge.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] data, input int lat, input string name);
        int cnt;
        wr_mem = wr; rd_mem = rd; addr_mem = addr; data_wr_mem = data;
        @(posedge clk); #1;
        wr_mem = 1'b0; rd_mem = 1'b0;
        checks++;
        if (busy_mem !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: busy_mem got %b expected 1", name, busy_mem);
        end
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (busy_mem === 1'b1) cnt++;
            else break;
        end
        checks++;
        if (cnt != lat) begin
            errors++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, cnt, lat);
        end
        if (wr) exp_wr++;
        else if (rd) exp_rd++;
        @(negedge clk);
    endtask

    task automatic check_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        do_access(1'b0, 1'b1, addr, 32'h0, RD_LAT, name);
        checks++;
        if (data_rd_mem !== exp) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, data_rd_mem, exp);
        end
    endtask

    task automatic check_counts(input string name);
        logic [31:0] er, ew;
        er = STATS ? 32'(exp_rd) : 32'd0;
        ew = STATS ? 32'(exp_wr) : 32'd0;
        checks++;
        if (rd_count !== er || wr_count !== ew) begin
            errors++;
            $display("FAIL %s counts: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
                     name, rd_count, wr_count, er, ew);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_mem = 1'b0; rd_mem = 1'b0; addr_mem = '0; data_wr_mem = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_mem !== 1'b0 || addr_err !== 1'b0 || data_rd_mem !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b err=%b rdata=%h expected 0 0 0",
                     busy_mem, addr_err, data_rd_mem);
        end
        exp_rd = 0; exp_wr = 0;
        check_counts("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Preload word 0, show it survives reset, then read it back.
    task automatic test_preload_read();
        do_access(1'b1, 1'b0, 32'h0, 32'h1234_5678, WR_LAT, "preload_wr");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rd = 0; exp_wr = 0;
        @(negedge clk);
        check_read(32'h0, 32'h1234_5678, "read0");
        check_counts("read0");
    endtask

    task automatic test_write_read();
        do_access(1'b1, 1'b0, 32'h10, 32'hA5A5_0001, WR_LAT, "wr10");
        checks++;
        if (data_rd_mem !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rdata_hold: got %h expected %h", data_rd_mem, 32'h1234_5678);
        end
        check_read(32'h10, 32'hA5A5_0001, "rd10");
        check_counts("wr_rd");
    endtask

    task automatic test_simultaneous();
        do_access(1'b1, 1'b1, 32'h20, 32'h55, WR_LAT, "wr_rd_both");
        check_counts("both");
        check_read(32'h20, 32'h55, "rd20");
    endtask

    task automatic test_busy_toggle();
        int cnt;
        wr_mem = 1'b1; addr_mem = 32'h8; data_wr_mem = 32'h77;
        @(posedge clk); #1;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            addr_mem = 32'h1C + 32'(i * 4); data_wr_mem = 32'hDEAD_0000 + 32'(i);
            @(posedge clk); #1;
            if (busy_mem === 1'b1) cnt++;
            else break;
        end
        wr_mem = 1'b0;
        exp_wr++;
        checks++;
        if (cnt != WR_LAT) begin
            errors++;
            $display("FAIL toggle busy_len: got %0d expected %0d", cnt, WR_LAT);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_mem !== 1'b0) begin
            errors++;
            $display("FAIL toggle extra_accept: busy_mem got %b expected 0", busy_mem);
        end
        @(negedge clk);
        check_read(32'h8, 32'h77, "rd8");
        check_counts("toggle");
    endtask

    task automatic test_reset_mid_write();
        do_access(1'b1, 1'b0, 32'h4, 32'h44, WR_LAT, "wr4_old");
        wr_mem = 1'b1; addr_mem = 32'h4; data_wr_mem = 32'h99;
        @(posedge clk); #1;
        wr_mem = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy_mem !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid busy: got %b expected 0", busy_mem);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rd = 0; exp_wr = 0;
        check_counts("rst_mid");
        checks++;
        if (data_rd_mem !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid rdata: got %h expected 0", data_rd_mem);
        end
        @(negedge clk);
        check_read(32'h4, 32'h44, "rd4");
    endtask

    task automatic test_out_of_range();
        do_access(1'b1, 1'b0, 32'h0001_0000, 32'h0BAD, WR_LAT, "oor_wr");
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_set: got %b expected 1", addr_err);
        end
        check_read(32'h0001_0000, 32'h0, "oor_rd");
        check_read(32'h0, 32'h1234_5678, "rd0_after_oor");
        checks++;
        if (addr_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_err_sticky: got %b expected 1", addr_err);
        end
        check_counts("oor");
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 32'h30, 32'hCAFE_F00D, WR_LAT, "b2b_wr");
        check_read(32'h30, 32'hCAFE_F00D, "b2b_rd");
        check_read(32'h3, 32'h1234_5678, "rd_lsb_ignored");
        check_counts("b2b");
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_preload_read();
        test_write_read();
        test_simultaneous();
        test_busy_toggle();
        test_reset_mid_write();
        test_preload_read();
        test_out_of_range();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_latency_responder.md
Name: mem_latency_responder

Overview:
- Synthesizable main-memory responder for the memory side of CacheController (wr_mem/rd_mem/addr_mem/data_wr_mem/data_rd_mem/busy_mem).
- Replaces the zero-wait behavioural RAM with a word-addressed single-port array.
- Access latency is configurable and signalled through busy_mem, so the cache's miss and write-back stall paths are exercised.
- Sits between CacheController and the top-level; one instance per cache.

Parameters:
- ADDR_W, 10: word-address bits; array depth is 2**ADDR_W words.
- DATA_W, 32: data width; must equal the cache's 32-bit memory bus.
- RD_LAT, 4: read latency in cycles; legal range 1..15.
- WR_LAT, 2: write latency in cycles; legal range 1..15.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_mem  in  1  write request from cache.
- rd_mem  in  1  read request from cache.
- addr_mem  in  32  byte address; word index is addr_mem[ADDR_W+1:2].
- data_wr_mem  in  DATA_W  write data.
- data_rd_mem  out  DATA_W  read data, registered.
- busy_mem  out  1  access in progress; requests are ignored while high.
- addr_err  out  1  sticky: an out-of-range address was accepted.
- rd_count  out  32  completed reads (MEM_STATS_EN).
- wr_count  out  32  completed writes (MEM_STATS_EN).

Behaviour:
- Reset values: data_rd_mem=0, busy_mem=0, addr_err=0, rd_count=0, wr_count=0, FSM=IDLE, latency counter=0.
- The array is not reset; its contents survive rst.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- Accept rule: at a rising edge in IDLE with (wr_mem|rd_mem)=1:
  - latch addr and wdata;
  - load counter with LAT-1;
  - set busy_mem=1;
  - go to RD_WAIT or WR_WAIT.
- Simultaneous wr_mem and rd_mem: write wins and the read is dropped.
- While waiting: the counter decrements each edge. At the edge where counter==0:
  - RD_WAIT: data_rd_mem <= array[latched index];
  - WR_WAIT: array[latched index] <= latched wdata;
  - in both cases busy_mem <= 0 and FSM returns to IDLE.
- Timing: busy_mem is high for exactly LAT cycles after the accept edge. Read data is valid from the edge that drops busy_mem and holds until the next read completes.
- Back-to-back: a request present at the edge after busy_mem falls is accepted, giving one idle cycle between accesses minimum.
- Inputs are don't-care while busy_mem=1. Changes to the inputs during busy do not affect the latched access.
- Out-of-range: if addr_mem[31:ADDR_W+2] != 0 at accept:
  - the access is still timed normally;
  - a write is discarded;
  - a read returns 32'h0;
  - addr_err is set and stays high until rst.
- addr_mem[1:0] is ignored (word access only).
- Reset mid-operation: the FSM returns to IDLE and busy_mem drops immediately (async). An in-flight write is not committed and an in-flight read does not update data_rd_mem.

Optional Feature:
- MEM_STATS_EN defined:
  - rd_count increments on each read completion, wr_count on each write completion (out-of-range accesses included);
  - both wrap modulo 2**32.
- MEM_STATS_EN undefined: rd_count and wr_count are tied to 0 and no counter flops are generated.

Decomposition:
- Package mem_resp_pkg:
  - state enum {IDLE, RD_WAIT, WR_WAIT};
  - LAT_CNT_W=4;
  - OOR_RDATA=32'h0.
- Sub-module mem_word_array: single-port synchronous RAM (we, index, wdata, rdata), write-first, no reset.
- The responder contains the FSM, latency counter, range check and statistics.

Test Plan:
- Reset, then a read at addr 0x0 with default parameters: busy_mem high for 4 cycles; data_rd_mem = preloaded word 0 on the falling-busy edge; rd_count=1.
- Write 0xA5A5_0001 to addr 0x10, then read 0x10: write busy for 2 cycles; read returns 0xA5A5_0001; wr_count=1, rd_count=1.
- wr_mem=rd_mem=1 at addr 0x20 with data 0x55: only the write happens (busy for 2 cycles); a later read of 0x20 returns 0x55; rd_count stays 0 from that request.
- Write to addr 0x0001_0000 (out of range for ADDR_W=10): addr_err=1 and stays set. A following read of the same address returns 0; a read of 0x0 is unchanged.
- Toggle addr_mem and data_wr_mem while busy during a write to 0x8 with data 0x77: array[2]=0x77 and no extra access is accepted.
- Assert rst during the 2nd busy cycle of a write of 0x99 to 0x4: busy_mem drops at once and a later read of 0x4 returns the old value.
